// File: rtl/pll_seq_pkg.sv
// Shared state encoding and default timing constants for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } seq_state_t;

  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_MAX_RETRIES         = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, waits for a stable lock, releases downstream reset and
// retries or faults when lock does not arrive in time.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       status_locked,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [7:0] loss_count
);

  localparam int CNT_MAX = max3(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT_CYCLES - 1);

  seq_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    retry_nxt;
  logic [7:0]    loss_nxt;
  logic          locked_s;

  sync_2ff u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (locked_s)
  );

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_count;
    loss_nxt  = loss_count;
    if (restart) begin
      state_nxt = ST_ASSERT_RST;
      retry_nxt = 2'd0;
    end else begin
      case (state)
        ST_ASSERT_RST: if (cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          // lock beats a timeout landing on the same cycle
          if (locked_s) state_nxt = ST_STABLE;
          else if (cnt == TO_LAST) begin
            if (int'(retry_count) < MAX_RETRIES) begin
              retry_nxt = retry_count + 2'd1;
              state_nxt = ST_ASSERT_RST;
            end else begin
              state_nxt = ST_FAULT;
            end
          end
        end
        ST_STABLE: begin
          if (!locked_s)               state_nxt = ST_WAIT_LOCK;
          else if (cnt == STABLE_LAST) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_nxt = ST_ASSERT_RST;
            retry_nxt = 2'd0;
            loss_nxt  = (loss_count != 8'hFF) ? loss_count + 8'd1 : loss_count;
          end
        end
        ST_FAULT: state_nxt = ST_FAULT;
        default:  state_nxt = ST_ASSERT_RST;
      endcase
    end
  end

  // Counter restarts on every state entry (and on restart); idle in RUN/FAULT.
  always_comb begin
    cnt_nxt = cnt + CW'(1);
    if (restart || (state_nxt != state))           cnt_nxt = '0;
    else if (state == ST_RUN || state == ST_FAULT) cnt_nxt = cnt;
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_ASSERT_RST;
      cnt           <= '0;
      retry_count   <= 2'd0;
      loss_count    <= 8'd0;
      pll_rst       <= 1'b1;
      sys_reset_n   <= 1'b0;
      status_locked <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      retry_count   <= retry_nxt;
      loss_count    <= loss_nxt;
      pll_rst       <= (state_nxt == ST_ASSERT_RST) || (state_nxt == ST_FAULT);
      sys_reset_n   <= (state_nxt == ST_RUN);
      status_locked <= (state_nxt == ST_RUN);
      fault         <= (state_nxt == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected output changes with their cycle;
// a negedge monitor pops and compares whenever the output tuple changes.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, pll_locked, restart;
  logic       pll_rst, sys_reset_n, status_locked, fault;
  logic [1:0] retry_count;
  logic [7:0] loss_count;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          cyc;
    logic [13:0] outs;
  } exp_t;

  exp_t sb[$];

  // {pll_rst, sys_reset_n, status_locked, fault, retry_count, loss_count}
  localparam logic [13:0] RST_T = {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .MAX_RETRIES         (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pll_locked    (pll_locked),
    .restart       (restart),
    .pll_rst       (pll_rst),
    .sys_reset_n   (sys_reset_n),
    .status_locked (status_locked),
    .fault         (fault),
    .retry_count   (retry_count),
    .loss_count    (loss_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [13:0] tup(input bit pr, input bit sn, input bit sl, input bit f,
                                      input logic [1:0] r, input logic [7:0] l);
    return {pr, sn, sl, f, r, l};
  endfunction

  function automatic logic [13:0] cur_outs();
    return {pll_rst, sys_reset_n, status_locked, fault, retry_count, loss_count};
  endfunction

  task automatic expect_ev(input string name, input int c, input logic [13:0] o);
    exp_t e;
    e.name = name; e.cyc = c; e.outs = o;
    sb.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [13:0] o);
    checks++;
    if (cur_outs() !== o) begin
      errors++;
      $display("FAIL %s: outs=%b expected %b", name, cur_outs(), o);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every change of the output tuple must match the next queued event.
  initial begin
    logic [13:0] prev, cur;
    exp_t e;
    prev = RST_T;
    forever begin
      @(negedge clk);
      cur = cur_outs();
      if (cur !== prev) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: cyc=%0d outs=%b (nothing expected)", cyc, cur);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || e.outs !== cur) begin
            errors++;
            $display("FAIL %s: got cyc=%0d outs=%b, expected cyc=%0d outs=%b",
                     e.name, cyc, cur, e.cyc, e.outs);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    int base, d, t, f;
    reset_n = 1'b1; pll_locked = 1'b0; restart = 1'b0;
    #1 reset_n = 1'b0;
    #1 check_now("reset_state", RST_T);
    repeat (2) @(negedge clk);

    // Normal start: 4-cycle pulse, then 2 sync + 1 detect + 8 stable cycles to RUN.
    base = cyc;
    reset_n = 1'b1;
    expect_ev("first_pulse_end", base + 4, tup(0, 0, 0, 0, 2'd0, 8'd0));
    wait_cyc(base + 10);
    pll_locked = 1'b1;
    expect_ev("run_normal", cyc + 11, tup(0, 1, 1, 0, 2'd0, 8'd0));
    wait_cyc(cyc + 15);

    // Loss in RUN, relock with a one-cycle glitch while STABLE.
    d = cyc;
    pll_locked = 1'b0;
    expect_ev("loss_assert", d + 3, tup(1, 0, 0, 0, 2'd0, 8'd1));
    expect_ev("loss_pulse_end", d + 7, tup(0, 0, 0, 0, 2'd0, 8'd1));
    wait_cyc(d + 10); pll_locked = 1'b1;
    wait_cyc(d + 15); pll_locked = 1'b0;
    wait_cyc(d + 16); pll_locked = 1'b1;
    expect_ev("run_after_glitch", d + 27, tup(0, 1, 1, 0, 2'd0, 8'd1));
    wait_cyc(d + 32);

    // Lock lost for good: two retries then FAULT.
    t = cyc;
    pll_locked = 1'b0;
    expect_ev("loss2_assert",   t + 3,   tup(1, 0, 0, 0, 2'd0, 8'd2));
    expect_ev("loss2_pulse_end", t + 7,  tup(0, 0, 0, 0, 2'd0, 8'd2));
    expect_ev("timeout1",       t + 39,  tup(1, 0, 0, 0, 2'd1, 8'd2));
    expect_ev("retry1_end",     t + 43,  tup(0, 0, 0, 0, 2'd1, 8'd2));
    expect_ev("timeout2",       t + 75,  tup(1, 0, 0, 0, 2'd2, 8'd2));
    expect_ev("retry2_end",     t + 79,  tup(0, 0, 0, 0, 2'd2, 8'd2));
    expect_ev("fault",          t + 111, tup(1, 0, 0, 1, 2'd2, 8'd2));
    wait_cyc(t + 120);

    // Restart out of FAULT, then restart colliding with a timeout.
    f = cyc;
    restart = 1'b1;
    expect_ev("restart_fault",  f + 1,  tup(1, 0, 0, 0, 2'd0, 8'd2));
    expect_ev("restart_pulse",  f + 5,  tup(0, 0, 0, 0, 2'd0, 8'd2));
    expect_ev("timeout_a",      f + 37, tup(1, 0, 0, 0, 2'd1, 8'd2));
    expect_ev("retry_a_end",    f + 41, tup(0, 0, 0, 0, 2'd1, 8'd2));
    expect_ev("restart_vs_to",  f + 73, tup(1, 0, 0, 0, 2'd0, 8'd2));
    expect_ev("restart2_pulse", f + 77, tup(0, 0, 0, 0, 2'd0, 8'd2));
    wait_cyc(f + 1);  restart = 1'b0;
    wait_cyc(f + 72); restart = 1'b1;
    wait_cyc(f + 73); restart = 1'b0;
    wait_cyc(f + 80); pll_locked = 1'b1;
    expect_ev("run_after_restart", f + 91, tup(0, 1, 1, 0, 2'd0, 8'd2));
    wait_cyc(f + 95);

    // Asynchronous reset in RUN.
    @(posedge clk);
    #2;
    expect_ev("mid_reset", cyc, RST_T);
    reset_n = 1'b0;
    #1 check_now("async_reset", RST_T);
    repeat (2) @(negedge clk);
    base = cyc;
    reset_n = 1'b1;
    expect_ev("rerst_pulse_end", base + 4,  tup(0, 0, 0, 0, 2'd0, 8'd0));
    expect_ev("rerst_run",       base + 13, tup(0, 1, 1, 0, 2'd0, 8'd0));
    wait_cyc(base + 20);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never seen, expected cyc=%0d outs=%b", e.name, e.cyc, e.outs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
